// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the CPU load/store stage and data_mem_ctrl.
// DMEM_PARITY_EN adds the parity_err response signal.
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              fault;
`ifdef DMEM_PARITY_EN
  logic              parity_err;

  modport master (output req, we, size, sign, addr, wdata,
                  input  ready, rvalid, rdata, fault, parity_err);
  modport slave  (input  req, we, size, sign, addr, wdata,
                  output ready, rvalid, rdata, fault, parity_err);
`else
  modport master (output req, we, size, sign, addr, wdata,
                  input  ready, rvalid, rdata, fault);
  modport slave  (input  req, we, size, sign, addr, wdata,
                  output ready, rvalid, rdata, fault);
`endif
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word access, sign/zero-extending loads, wait states.
// Define DMEM_PARITY_EN to add per-lane even parity and the parity_err response flag.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input logic            clk,
  input logic            reset,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W     = 4;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              fault;

  logic              l_we;
  logic [1:0]        l_size;
  logic              l_sign;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;

  logic              c_we;
  logic [1:0]        c_size;
  logic              c_sign;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;

  logic              accept;
  logic              enter_resp;
  logic              flt;
  logic [ADDR_W-3:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        lane_mask;
  logic [3:0][7:0]   wr_word;
  logic [3:0][7:0]   rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;

  logic [3:0][7:0]   mem [DEPTH_WORDS];

  assign bus.ready  = ready;
  assign bus.rvalid = rvalid;
  assign bus.rdata  = rdata;
  assign bus.fault  = fault;

  // Request view: the live bus while idle (acceptance edge), the latched copy afterwards
  always_comb begin
    c_we       = l_we;
    c_size     = l_size;
    c_sign     = l_sign;
    c_addr     = l_addr;
    c_wdata    = l_wdata;
    if (state == S_IDLE) begin
      c_we    = bus.we;
      c_size  = bus.size;
      c_sign  = bus.sign;
      c_addr  = bus.addr;
      c_wdata = bus.wdata;
    end
    accept     = ready && bus.req;
    enter_resp = (accept && NO_WAIT) || ((state == S_WAIT) && (cnt == CNT_W'(1)));
    word_addr  = c_addr[ADDR_W-1:2];
    idx        = IDX_W'(word_addr);
    flt        = ((c_size == 2'b01) && c_addr[0])
              || ((c_size == 2'b10) && (c_addr[1:0] != 2'b00))
              || (c_size == 2'b11)
              || (64'(word_addr) >= 64'(DEPTH_WORDS));
  end

  // Lane selection, store replication and load extension
  always_comb begin
    lane_mask = 4'b0000;
    wr_word   = c_wdata;
    rd_word   = mem[idx];
    ld_byte   = rd_word[c_addr[1:0]];
    ld_half   = c_addr[1] ? rd_word[3:2] : rd_word[1:0];
    ld_val    = 32'h0;
    case (c_size)
      2'b00: begin
        lane_mask = 4'b0001 << c_addr[1:0];
        wr_word   = {4{c_wdata[7:0]}};
        ld_val    = {{24{c_sign & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        lane_mask = c_addr[1] ? 4'b1100 : 4'b0011;
        wr_word   = {2{c_wdata[15:0]}};
        ld_val    = {{16{c_sign & ld_half[15]}}, ld_half};
      end
      2'b10: begin
        lane_mask = 4'b1111;
        ld_val    = rd_word;
      end
      default: ;
    endcase
  end

  // Array write on entry into RESP; faulting stores never reach here
  always_ff @(posedge clk) begin
    if (enter_resp && c_we && !flt) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[idx][i] <= wr_word[i];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH_WORDS];
  logic [3:0] calc_par;
  logic       pe_c;
  logic       parity_err;

  assign bus.parity_err = parity_err;

  always_comb begin
    calc_par = 4'b0000;
    for (int i = 0; i < 4; i++) calc_par[i] = ^rd_word[i];
    pe_c = |(lane_mask & (calc_par ^ par_mem[idx]));
  end

  always_ff @(posedge clk) begin
    if (enter_resp && c_we && !flt) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) par_mem[idx][i] <= ^wr_word[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          parity_err <= 1'b0;
    else if (enter_resp) parity_err <= !c_we && !flt && pe_c;
    else                 parity_err <= 1'b0;
  end
`endif

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      fault   <= 1'b0;
      l_we    <= 1'b0;
      l_size  <= 2'b00;
      l_sign  <= 1'b0;
      l_addr  <= '0;
      l_wdata <= 32'h0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            l_we    <= bus.we;
            l_size  <= bus.size;
            l_sign  <= bus.sign;
            l_addr  <= bus.addr;
            l_wdata <= bus.wdata;
            ready   <= 1'b0;
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end else begin
            ready <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        rvalid <= 1'b1;
        fault  <= flt;
        rdata  <= (c_we || flt) ? 32'h0 : ld_val;
      end
    end
  end

endmodule
